llc_mem_req_queue: RTL and testbench

- Buffers memory requests from the LLC core toward the memory interface; it sits downstream of the core's memory-request output.
- Holds requests in order, caps the number of outstanding line reads, and returns memory responses to the core through a one-entry registered stage.
- Decouples core stalls in PROCESS/UPDATE from memory backpressure.

---
 rtl/llc_mem_req_queue_pkg.sv | 19 +
 rtl/llc_mem_rsp_reg.sv | 46 ++++
 rtl/llc_mem_req_queue.sv | 144 ++++++++++++++
 tb/tb_llc_mem_req_queue.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/llc_mem_req_queue_pkg.sv
// Shared constants and the request-entry layout for the LLC memory request queue.
package llc_mem_req_queue_pkg;

  localparam int LLC_MEMQ_DEPTH  = 4;
  localparam int LLC_MAX_RD      = 2;
  localparam int LLC_ADDR_BITS   = 26;
  localparam int LLC_LINE_BITS   = 128;
  localparam int LLC_HPROT_BITS  = 1;
  localparam int LLC_HSIZE_BITS  = 3;

  typedef struct packed {
    logic                      hwrite;
    logic [LLC_HSIZE_BITS-1:0] hsize;
    logic [LLC_HPROT_BITS-1:0] hprot;
    logic [LLC_ADDR_BITS-1:0]  addr;
    logic [LLC_LINE_BITS-1:0]  line;
  } mem_req_entry_t;

endpackage

// File: rtl/llc_mem_rsp_reg.sv
// One-entry valid/ready register carrying memory read data back to the core.
module llc_mem_rsp_reg #(
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // Accept whenever the slot is empty or drains this cycle, giving full throughput.
  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // Next-state: capture on input handshake, clear on output handshake alone.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_valid && in_ready) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/llc_mem_req_queue.sv
// In-order memory request queue with an outstanding-read cap and a registered
// response return path.
module llc_mem_req_queue
  import llc_mem_req_queue_pkg::*;
#(
  parameter int DEPTH      = LLC_MEMQ_DEPTH,
  parameter int MAX_RD     = LLC_MAX_RD,
  parameter int ADDR_BITS  = LLC_ADDR_BITS,
  parameter int LINE_BITS  = LLC_LINE_BITS,
  parameter int HPROT_BITS = LLC_HPROT_BITS,
  parameter int HSIZE_BITS = LLC_HSIZE_BITS,
  localparam int RD_W      = $clog2(MAX_RD + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_in_valid,
  output logic                  req_in_ready,
  input  logic                  req_in_hwrite,
  input  logic [HSIZE_BITS-1:0] req_in_hsize,
  input  logic [HPROT_BITS-1:0] req_in_hprot,
  input  logic [ADDR_BITS-1:0]  req_in_addr,
  input  logic [LINE_BITS-1:0]  req_in_line,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_hwrite,
  output logic [HSIZE_BITS-1:0] mem_req_hsize,
  output logic [HPROT_BITS-1:0] mem_req_hprot,
  output logic [ADDR_BITS-1:0]  mem_req_addr,
  output logic [LINE_BITS-1:0]  mem_req_line,
  input  logic                  mem_rsp_in_valid,
  output logic                  mem_rsp_in_ready,
  input  logic [LINE_BITS-1:0]  mem_rsp_in_line,
  output logic                  mem_rsp_out_valid,
  input  logic                  mem_rsp_out_ready,
  output logic [LINE_BITS-1:0]  mem_rsp_out_line,
  output logic [RD_W-1:0]       rd_outstanding,
  output logic                  rsp_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  mem_req_entry_t       mem_q [DEPTH];
  mem_req_entry_t       in_entry;
  mem_req_entry_t       head;

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [RD_W-1:0]      rd_out_q, rd_out_d;
  logic                 rsp_err_q, rsp_err_d;

  logic                 not_empty;
  logic                 push;
  logic                 pop;
  logic                 rd_pop;
  logic                 rsp_hs;

  assign in_entry = '{hwrite: req_in_hwrite, hsize: req_in_hsize, hprot: req_in_hprot,
                      addr: req_in_addr, line: req_in_line};

  // Fields read as zero while empty so nothing stale leaks onto the memory bus.
  assign not_empty = (count_q != '0);
  assign head      = not_empty ? mem_q[rd_ptr_q] : '0;

  // Ready depends on registered occupancy only: a pop never frees a slot in the same cycle.
  assign req_in_ready  = (count_q != CNT_W'(DEPTH));
  // Writes bypass the read cap, but a gated read still blocks everything behind it.
  assign mem_req_valid = not_empty && (head.hwrite || (rd_out_q < RD_W'(MAX_RD)));

  assign mem_req_hwrite = head.hwrite;
  assign mem_req_hsize  = head.hsize;
  assign mem_req_hprot  = head.hprot;
  assign mem_req_addr   = head.addr;
  assign mem_req_line   = head.line;

  assign push   = req_in_valid && req_in_ready;
  assign pop    = mem_req_valid && mem_req_ready;
  assign rd_pop = pop && !head.hwrite;
  assign rsp_hs = mem_rsp_in_valid && mem_rsp_in_ready;

  assign rd_outstanding = rd_out_q;
  assign rsp_err        = rsp_err_q;

  // Next-state for pointers, occupancy, read tracking and the sticky error.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_out_d  = rd_out_q;
    rsp_err_d = rsp_err_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);

    if (rd_pop && !rsp_hs) begin
      rd_out_d = rd_out_q + RD_W'(1);
    end else if (!rd_pop && rsp_hs && (rd_out_q != '0)) begin
      rd_out_d = rd_out_q - RD_W'(1);
    end

    // A response with nothing in flight is flagged; its data is still forwarded.
    if (rsp_hs && (rd_out_q == '0)) rsp_err_d = 1'b1;
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_out_q  <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_out_q  <= rd_out_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  // Entry storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_entry;
  end

  llc_mem_rsp_reg #(
    .W (LINE_BITS)
  ) u_rsp_reg (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (mem_rsp_in_valid),
    .in_ready  (mem_rsp_in_ready),
    .in_data   (mem_rsp_in_line),
    .out_valid (mem_rsp_out_valid),
    .out_ready (mem_rsp_out_ready),
    .out_data  (mem_rsp_out_line)
  );

endmodule

// File: tb/tb_llc_mem_req_queue.sv
// Directed bench for llc_mem_req_queue with default parameters (DEPTH=4, MAX_RD=2).
module tb_llc_mem_req_queue;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_in_valid;
  logic         req_in_ready;
  logic         req_in_hwrite;
  logic [2:0]   req_in_hsize;
  logic [0:0]   req_in_hprot;
  logic [25:0]  req_in_addr;
  logic [127:0] req_in_line;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic         mem_req_hwrite;
  logic [2:0]   mem_req_hsize;
  logic [0:0]   mem_req_hprot;
  logic [25:0]  mem_req_addr;
  logic [127:0] mem_req_line;
  logic         mem_rsp_in_valid;
  logic         mem_rsp_in_ready;
  logic [127:0] mem_rsp_in_line;
  logic         mem_rsp_out_valid;
  logic         mem_rsp_out_ready;
  logic [127:0] mem_rsp_out_line;
  logic [1:0]   rd_outstanding;
  logic         rsp_err;

  int checks = 0;
  int errors = 0;

  logic [127:0] line_aa;
  logic [127:0] line_bb;
  logic [127:0] line_cc;
  logic [127:0] line_r1;
  logic [127:0] line_r2;

  always #5 clk = ~clk;

  llc_mem_req_queue dut (
    .clk               (clk),
    .rst               (rst),
    .req_in_valid      (req_in_valid),
    .req_in_ready      (req_in_ready),
    .req_in_hwrite     (req_in_hwrite),
    .req_in_hsize      (req_in_hsize),
    .req_in_hprot      (req_in_hprot),
    .req_in_addr       (req_in_addr),
    .req_in_line       (req_in_line),
    .mem_req_valid     (mem_req_valid),
    .mem_req_ready     (mem_req_ready),
    .mem_req_hwrite    (mem_req_hwrite),
    .mem_req_hsize     (mem_req_hsize),
    .mem_req_hprot     (mem_req_hprot),
    .mem_req_addr      (mem_req_addr),
    .mem_req_line      (mem_req_line),
    .mem_rsp_in_valid  (mem_rsp_in_valid),
    .mem_rsp_in_ready  (mem_rsp_in_ready),
    .mem_rsp_in_line   (mem_rsp_in_line),
    .mem_rsp_out_valid (mem_rsp_out_valid),
    .mem_rsp_out_ready (mem_rsp_out_ready),
    .mem_rsp_out_line  (mem_rsp_out_line),
    .rd_outstanding    (rd_outstanding),
    .rsp_err           (rsp_err)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are checked 1 ns later.
  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [127:0] wline(input int i);
    return {4{32'hC0DE_0000 + i}};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    line_aa = {16{8'hAA}};
    line_bb = {16{8'hBB}};
    line_cc = {16{8'hCC}};
    line_r1 = {8{16'h1111}};
    line_r2 = {8{16'h2222}};

    rst = 1'b0;
    req_in_valid = 0; req_in_hwrite = 0; req_in_hsize = 0; req_in_hprot = 0;
    req_in_addr = 0; req_in_line = 0; mem_req_ready = 0;
    mem_rsp_in_valid = 0; mem_rsp_in_line = 0; mem_rsp_out_ready = 0;

    // Reset state
    #12;
    chk("rst_req_in_ready", req_in_ready, 1);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_mem_rsp_out_valid", mem_rsp_out_valid, 0);
    chk("rst_rd_outstanding", rd_outstanding, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_mem_rsp_in_ready", mem_rsp_in_ready, 1);
    chk("rst_mem_req_addr", mem_req_addr, 0);
    nxt(); rst = 1'b1;

    // Fill with four writes while memory stalls
    for (int i = 0; i < 4; i++) begin
      nxt();
      req_in_valid = 1; req_in_hwrite = 1; req_in_hsize = 3'd4; req_in_hprot = 1'b1;
      req_in_addr = 26'h10 + 26'(i); req_in_line = wline(i);
      settle();
      chk("fill_ready", req_in_ready, 1);
      if (i == 0) chk("no_bypass_valid", mem_req_valid, 0);
    end
    nxt();
    // Full: offer 0x14 while popping 0x10; the push must not be taken
    req_in_addr = 26'h14; req_in_line = wline(4); mem_req_ready = 1;
    settle();
    chk("full_ready", req_in_ready, 0);
    chk("full_valid", mem_req_valid, 1);
    chk("issue0_addr", mem_req_addr, 26'h10);
    chk("issue0_line", mem_req_line, wline(0));
    chk("issue0_hsize", mem_req_hsize, 3'd4);
    chk("issue0_hprot", mem_req_hprot, 1);
    for (int i = 1; i < 4; i++) begin
      nxt(); req_in_valid = 0; settle();
      chk("issue_valid", mem_req_valid, 1);
      chk("issue_addr", mem_req_addr, 26'h10 + 26'(i));
      chk("issue_line", mem_req_line, wline(i));
    end
    nxt(); settle();
    chk("drained_valid", mem_req_valid, 0);
    chk("drained_ready", req_in_ready, 1);

    // Three reads against MAX_RD=2
    mem_req_ready = 0;
    for (int i = 0; i < 3; i++) begin
      nxt();
      req_in_valid = 1; req_in_hwrite = 0; req_in_hsize = 3'd4; req_in_hprot = 0;
      req_in_addr = 26'h20 + 26'(i); req_in_line = 0;
    end
    nxt(); req_in_valid = 0; mem_req_ready = 1; settle();
    chk("rd0_valid", mem_req_valid, 1);
    chk("rd0_addr", mem_req_addr, 26'h20);
    chk("rd0_hwrite", mem_req_hwrite, 0);
    chk("rd0_out", rd_outstanding, 0);
    nxt(); settle();
    chk("rd1_addr", mem_req_addr, 26'h21);
    chk("rd1_out", rd_outstanding, 1);
    nxt(); settle();
    chk("rd2_gated_valid", mem_req_valid, 0);
    chk("rd2_gated_addr", mem_req_addr, 26'h22);
    chk("rd2_out", rd_outstanding, 2);
    nxt(); settle();
    chk("rd2_still_gated", mem_req_valid, 0);
    mem_rsp_in_valid = 1; mem_rsp_in_line = line_r1; mem_rsp_out_ready = 1;
    settle();
    chk("rsp1_in_ready", mem_rsp_in_ready, 1);
    nxt(); mem_rsp_in_valid = 0; settle();
    chk("rsp1_out_valid", mem_rsp_out_valid, 1);
    chk("rsp1_out_line", mem_rsp_out_line, line_r1);
    chk("rd2_released_valid", mem_req_valid, 1);
    chk("rd2_released_addr", mem_req_addr, 26'h22);
    chk("rd2_released_out", rd_outstanding, 1);
    nxt(); settle();
    chk("rd2_issued_out", rd_outstanding, 2);
    chk("rd2_issued_empty", mem_req_valid, 0);
    chk("rsp1_cleared", mem_rsp_out_valid, 0);

    // Gated read at head blocks a write behind it
    nxt(); req_in_valid = 1; req_in_hwrite = 0; req_in_addr = 26'h23;
    nxt(); req_in_hwrite = 1; req_in_addr = 26'h30; req_in_line = wline(9); settle();
    chk("ord_rd_gated", mem_req_valid, 0);
    chk("ord_head_addr", mem_req_addr, 26'h23);
    nxt(); req_in_valid = 0; settle();
    chk("ord_wr_blocked", mem_req_valid, 0);
    chk("ord_wr_blocked_addr", mem_req_addr, 26'h23);
    mem_rsp_in_valid = 1; mem_rsp_in_line = line_r2;
    nxt(); mem_rsp_in_valid = 0; settle();
    chk("ord_rd_valid", mem_req_valid, 1);
    chk("ord_rd_addr", mem_req_addr, 26'h23);
    chk("ord_rsp2_line", mem_rsp_out_line, line_r2);
    nxt(); settle();
    chk("ord_wr_valid", mem_req_valid, 1);
    chk("ord_wr_addr", mem_req_addr, 26'h30);
    chk("ord_wr_hwrite", mem_req_hwrite, 1);
    chk("ord_wr_line", mem_req_line, wline(9));
    chk("ord_out_full", rd_outstanding, 2);
    nxt(); settle();
    chk("ord_empty", mem_req_valid, 0);
    chk("ord_out_after_wr", rd_outstanding, 2);

    // Response backpressure from the core
    mem_rsp_out_ready = 0; mem_rsp_in_valid = 1; mem_rsp_in_line = line_aa;
    nxt(); mem_rsp_in_line = line_bb; settle();
    chk("hold_valid", mem_rsp_out_valid, 1);
    chk("hold_line_aa", mem_rsp_out_line, line_aa);
    chk("hold_in_ready", mem_rsp_in_ready, 0);
    chk("hold_out_cnt", rd_outstanding, 1);
    nxt(); settle();
    chk("hold2_line_aa", mem_rsp_out_line, line_aa);
    chk("hold2_out_cnt", rd_outstanding, 1);
    mem_rsp_out_ready = 1; settle();
    chk("drain_in_ready", mem_rsp_in_ready, 1);
    nxt(); mem_rsp_in_valid = 0; settle();
    chk("bb_valid", mem_rsp_out_valid, 1);
    chk("bb_line", mem_rsp_out_line, line_bb);
    chk("bb_out_cnt", rd_outstanding, 0);
    chk("bb_no_err", rsp_err, 0);
    nxt(); settle();
    chk("bb_cleared", mem_rsp_out_valid, 0);

    // Unexpected response, then reset mid-queue
    mem_rsp_in_valid = 1; mem_rsp_in_line = line_cc;
    nxt(); mem_rsp_in_valid = 0; settle();
    chk("err_set", rsp_err, 1);
    chk("err_out_cnt", rd_outstanding, 0);
    chk("err_line_fwd", mem_rsp_out_line, line_cc);
    chk("err_valid_fwd", mem_rsp_out_valid, 1);
    mem_rsp_out_ready = 0; mem_req_ready = 0;
    req_in_valid = 1; req_in_hwrite = 1; req_in_addr = 26'h40; req_in_line = wline(5);
    nxt(); req_in_valid = 0; settle();
    chk("err_sticky", rsp_err, 1);
    chk("q40_valid", mem_req_valid, 1);
    rst = 1'b0; settle();
    chk("mid_rst_valid", mem_req_valid, 0);
    chk("mid_rst_err", rsp_err, 0);
    chk("mid_rst_ready", req_in_ready, 1);
    chk("mid_rst_rsp_valid", mem_rsp_out_valid, 0);
    chk("mid_rst_addr", mem_req_addr, 0);
    nxt(); rst = 1'b1;
    nxt(); settle();
    chk("post_rst_empty", mem_req_valid, 0);
    chk("post_rst_rsp", mem_rsp_out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
